// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
// Shares one sram-like master port between instruction fetch (inst) and the
// load/store path (data). Data has fixed priority. A starvation counter
// forces an inst grant after STARVE_LIMIT consecutive data grants made while
// inst was waiting. Only one transaction is outstanding at a time, and the
// winner's request fields are latched at grant so requesters may drop them
// right after addr_ok.
//
// STARVE_LIMIT must be representable in CNT_W bits (2**CNT_W > STARVE_LIMIT).

module sram_req_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        reset,

    // instruction fetch port (read-only, word sized)
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // load/store port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    // shared master port towards the sram-like slave / bridge
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0]       SIZE_WORD = 2'd2;
    localparam logic             OWNER_INST = 1'b0;
    localparam logic             OWNER_DATA = 1'b1;

    // FSM and latched request fields
    state_t            r_state;
    logic              r_owner;
    logic              r_m_req;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;

    // fairness and read-data mirrors
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [31:0]       r_inst_rdata;
    logic [31:0]       r_data_rdata;

    // combinational grant / completion decode
    logic              w_idle;
    logic              w_force_inst;
    logic              w_grant_data;
    logic              w_grant_inst;
    logic              w_done;
    logic              w_inst_done;
    logic              w_data_done;

    // Grant and completion decode. Nothing is granted or completed while
    // reset is asserted, so a reset cycle never produces a handshake pulse.
    always_comb begin
        w_idle       = (r_state == ST_IDLE) && !reset;
        w_force_inst = (r_starve_cnt == LIMIT_C);
        w_grant_data = w_idle && data_req && !(w_force_inst && inst_req);
        w_grant_inst = w_idle && inst_req && !w_grant_data;
        // Completion either in DATA, or in ADDR when the slave accepts the
        // address and finishes in the same cycle.
        w_done       = !reset &&
                       (((r_state == ST_ADDR) && m_addr_ok && m_data_ok) ||
                        ((r_state == ST_DATA) && m_data_ok));
        w_inst_done  = w_done && (r_owner == OWNER_INST);
        w_data_done  = w_done && (r_owner == OWNER_DATA);
    end

    // Main FSM: grant in IDLE, address phase in ADDR, wait for data in DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= OWNER_INST;
            r_m_req <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_data) begin
                        r_owner <= OWNER_DATA;
                        r_wr    <= data_wr;
                        r_size  <= data_size;
                        r_addr  <= data_addr;
                        r_wdata <= data_wdata;
                        r_m_req <= 1'b1;
                        r_state <= ST_ADDR;
                    end else if (w_grant_inst) begin
                        r_owner <= OWNER_INST;
                        r_wr    <= 1'b0;
                        r_size  <= SIZE_WORD;
                        r_addr  <= inst_addr;
                        r_wdata <= 32'd0;
                        r_m_req <= 1'b1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // m_data_ok without m_addr_ok is a stray and is ignored.
                    if (m_addr_ok) begin
                        r_m_req <= 1'b0;
                        r_state <= m_data_ok ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_m_req <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch,
    // saturates at the limit, and clears on any grant with no fetch waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_data) begin
            if (inst_req) begin
                if (r_starve_cnt != LIMIT_C) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end else if (w_grant_inst) begin
            r_starve_cnt <= '0;
        end
    end

    // Read-data mirrors hold the last delivered word for each requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_rdata <= 32'd0;
            r_data_rdata <= 32'd0;
        end else begin
            if (w_inst_done) begin
                r_inst_rdata <= m_rdata;
            end
            if (w_data_done) begin
                r_data_rdata <= m_rdata;
            end
        end
    end

    // Requester-side handshakes; rdata passes straight through on completion.
    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = w_inst_done;
    assign data_data_ok = w_data_done;
    assign inst_rdata   = w_inst_done ? m_rdata : r_inst_rdata;
    assign data_rdata   = w_data_done ? m_rdata : r_data_rdata;

    // Master side is driven entirely from registers.
    assign m_req   = r_m_req;
    assign m_wr    = r_wr;
    assign m_size  = r_size;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

endmodule
